// File: rtl/display_capture.sv
// Panel-side receiver for the serial row/column PWM display interface.
// Rebuilds pixel intensities by counting the lit display periods and writes each finished row out.
module display_capture #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3*segments-1:0]           rgb,
  input  logic                            oclk,
  input  logic                            lat,
  input  logic                            oe,
  input  logic [$clog2(rows)-1:0]         row,
  output logic                            wr_en,
  output logic [$clog2(rows)-1:0]         wr_row,
  output logic [$clog2(columns)-1:0]      wr_col,
  output logic [bitwidth*3*segments-1:0]  wr_pixel,
  output logic                            frame_sync,
  output logic                            framing_error
);

  localparam int SW   = 3 * segments;
  localparam int NCH  = columns * SW;
  localparam int RW   = $clog2(rows);
  localparam int CW   = $clog2(columns);
  localparam int SCW  = $clog2(columns + 1);
  localparam int CNTW = bitwidth + 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(1) << bitwidth;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state;
  logic                oclk_q, lat_q, oe_q;
  logic                oclk_rise, lat_rise, oe_rise, row_change;
  logic [NCH-1:0]      shift_reg, shift_next, latch_reg;
  logic [SCW-1:0]      shift_cnt, shift_cnt_next;
  logic [RW-1:0]       row_reg, flush_row;
  logic [CW-1:0]       col_reg;
  logic [NCH*CNTW-1:0] buf_flat;
  logic [bitwidth*SW-1:0] pix_next;

  assign oclk_rise  = oclk & ~oclk_q;
  assign lat_rise   = lat & ~lat_q;
  assign oe_rise    = oe & ~oe_q;
  assign row_change = (row != row_reg);

  // The shift is resolved first so a coincident latch strobe captures the post-shift data.
  always_comb begin
    shift_next     = shift_reg;
    shift_cnt_next = shift_cnt;
    if (oclk_rise) begin
      shift_next = {rgb, shift_reg[NCH-1:SW]};
      if (shift_cnt != SCW'(columns))
        shift_cnt_next = shift_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cnt
      logic [CNTW-1:0] cnt_reg, buf_reg;
      logic            hit;
      assign hit = oe_rise & latch_reg[gi];
      // On a row change the counter restarts, so a coincident oe rise belongs to the new row.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
          buf_reg <= '0;
        end else if (row_change) begin
          buf_reg <= cnt_reg;
          cnt_reg <= {{(CNTW-1){1'b0}}, hit};
        end else if (hit && cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign buf_flat[gi*CNTW +: CNTW] = buf_reg;
    end

    // A value p > 0 lights p+1 periods, so a count n maps back to n-1.
    for (gi = 0; gi < SW; gi++) begin : g_pix
      logic [CNTW-1:0] cnt_sel;
      assign cnt_sel = buf_flat[(int'(col_reg) * SW + gi) * CNTW +: CNTW];
      assign pix_next[gi*bitwidth +: bitwidth] =
        (cnt_sel == '0) ? '0 : bitwidth'(cnt_sel - 1'b1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      oclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_q          <= 1'b0;
      shift_reg     <= '0;
      shift_cnt     <= '0;
      latch_reg     <= '0;
      row_reg       <= '0;
      flush_row     <= '0;
      col_reg       <= '0;
      state         <= IDLE;
      wr_en         <= 1'b0;
      wr_row        <= '0;
      wr_col        <= '0;
      wr_pixel      <= '0;
      frame_sync    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      oclk_q    <= oclk;
      lat_q     <= lat;
      oe_q      <= oe;
      shift_reg <= shift_next;
      shift_cnt <= lat_rise ? '0 : shift_cnt_next;
      if (lat_rise) begin
        latch_reg <= shift_next;
        if (shift_cnt_next != SCW'(columns) || oe)
          framing_error <= 1'b1;
      end
      frame_sync <= row_change && (row_reg == RW'(rows - 1)) && (row == '0);
      if (row_change) begin
        // A row change mid-flush drops the rest of the old row and restarts on the new buffer.
        row_reg   <= row;
        flush_row <= row_reg;
        col_reg   <= '0;
        state     <= WRITE;
        wr_en     <= 1'b0;
        if (state == WRITE)
          framing_error <= 1'b1;
      end else begin
        case (state)
          IDLE: wr_en <= 1'b0;
          WRITE: begin
            wr_en    <= 1'b1;
            wr_row   <= flush_row;
            wr_col   <= col_reg;
            wr_pixel <= pix_next;
            if (col_reg == CW'(columns - 1))
              state <= IDLE;
            else
              col_reg <= col_reg + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Directed plus randomized bench for display_capture; expected pixels come from counting lit
// display periods per channel and mapping the count back to an intensity.
module tb_display_capture;

  localparam int COLS = 32;
  localparam int ROWS = 8;
  localparam int BW   = 8;
  localparam int SW   = 3;
  localparam int NCH  = COLS * SW;
  localparam int RW   = 3;
  localparam int CW   = 5;
  localparam int PW   = BW * SW;

  typedef int cnt_t [NCH];
  typedef struct {
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [PW-1:0] p;
    int            t;
  } wr_t;

  logic clk = 1'b0;
  logic rst, oclk, lat, oe;
  logic [SW-1:0] rgb;
  logic [RW-1:0] row;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [PW-1:0] wr_pixel;
  logic          frame_sync, framing_error;

  display_capture #(.segments(1), .rows(ROWS), .columns(COLS), .bitwidth(BW)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .oclk(oclk), .lat(lat), .oe(oe), .row(row),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_pixel(wr_pixel),
    .frame_sync(frame_sync), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  wr_t wr_q[$];
  logic [ROWS-1:0] row_seen = '0;

  // Reference model state
  logic [NCH-1:0] shifted, latched, bits;
  cnt_t cnt, snap_a, snap_b, snap_c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (wr_en === 1'b1) begin
      w.r = wr_row; w.c = wr_col; w.p = wr_pixel; w.t = cyc;
      wr_q.push_back(w);
      if (wr_col == CW'(COLS - 1)) row_seen[wr_row] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [NCH-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      rgb = b[k*SW +: SW];
      oclk = 1'b1; tick();
      oclk = 1'b0; tick();
    end
    rgb = '0;
    shifted = b;
  endtask

  task automatic latch_now();
    lat = 1'b1; tick();
    lat = 1'b0; tick();
    latched = shifted;
  endtask

  task automatic oe_pulse();
    oe = 1'b1; tick();
    oe = 1'b0; tick();
    for (int i = 0; i < NCH; i++)
      if (latched[i] && cnt[i] < (1 << BW)) cnt[i]++;
  endtask

  task automatic change_row(input logic [RW-1:0] r);
    row = r;
    tick();
    snap_a = cnt;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
  endtask

  function automatic logic [PW-1:0] pix_of(input cnt_t s, input int k);
    logic [PW-1:0] px;
    px = '0;
    for (int c = 0; c < SW; c++)
      px[c*BW +: BW] = (s[k*SW + c] == 0) ? 8'd0 : 8'(s[k*SW + c] - 1);
    return px;
  endfunction

  task automatic wait_writes(input int n, input string tag);
    for (int i = 0; i < 300 && wr_q.size() < n; i++) tick();
    repeat (3) tick();
    check({tag, "_count"}, 64'(wr_q.size()), 64'(n));
  endtask

  task automatic check_writes(input cnt_t s, input int r, input int ncol, input string tag);
    wr_t w;
    for (int k = 0; k < ncol; k++) begin
      if (wr_q.size() == 0) break;
      w = wr_q.pop_front();
      check($sformatf("%s_c%0d", tag, k), {w.r, w.c, w.p}, {RW'(r), CW'(k), pix_of(s, k)});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    check({tag, "_wr_row"}, 64'(wr_row), 64'(0));
    check({tag, "_wr_col"}, 64'(wr_col), 64'(0));
    check({tag, "_wr_pixel"}, 64'(wr_pixel), 64'(0));
    check({tag, "_frame_sync"}, 64'(frame_sync), 64'(0));
    check({tag, "_framing_error"}, 64'(framing_error), 64'(0));
  endtask

  initial begin
    wr_t w;
    int  rc_cyc;
    logic found;

    rst = 1'b1; oclk = 1'b0; lat = 1'b0; oe = 1'b0; rgb = '0; row = '0;
    shifted = '0; latched = '0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Row 0: column k shows R=k, G=0, B=255 over 256 display periods.
    for (int t = 0; t < 256; t++) begin
      bits = '0;
      for (int k = 0; k < COLS; k++) begin
        bits[k*SW + 0] = (k > 0) && (t <= k);
        bits[k*SW + 2] = 1'b1;
      end
      shift_bits(bits, COLS);
      latch_now();
      oe_pulse();
    end
    change_row(1);
    rc_cyc = cyc;
    check("row0to1_frame_sync", 64'(frame_sync), 64'(0));
    wait_writes(COLS, "row0");
    if (wr_q.size() > 0) check("first_write_latency", 64'(wr_q[0].t - rc_cyc), 64'(1));
    for (int k = 0; k < COLS; k++) begin
      if (wr_q.size() == 0) break;
      w = wr_q.pop_front();
      check($sformatf("row0_c%0d", k), {w.r, w.c, w.p}, {3'd0, CW'(k), 8'd255, 8'd0, 8'(k)});
    end
    check("clean_rows_no_error", 64'(framing_error), 64'(0));

    // Rows 1..7 with random bits, then wrap to row 0.
    for (int r = 1; r < ROWS; r++) begin
      for (int t = 0; t < 8; t++) begin
        for (int i = 0; i < NCH; i++) bits[i] = 1'($urandom_range(0, 1));
        shift_bits(bits, COLS);
        latch_now();
        oe_pulse();
      end
      change_row(RW'((r + 1) % ROWS));
      check($sformatf("frame_sync_r%0d", r), 64'(frame_sync), 64'(r == ROWS - 1));
      if (r == ROWS - 1) begin
        tick();
        check("frame_sync_one_cycle", 64'(frame_sync), 64'(0));
      end
      wait_writes(COLS, $sformatf("row%0d", r));
      check_writes(snap_a, r, COLS, $sformatf("row%0d", r));
    end
    check("all_rows_written", 64'(row_seen), 64'({ROWS{1'b1}}));

    // 300 periods with every bit lit: counters saturate.
    bits = '1;
    shift_bits(bits, COLS);
    latch_now();
    repeat (300) oe_pulse();
    change_row(1);
    wait_writes(COLS, "sat");
    for (int k = 0; k < COLS; k++) begin
      if (wr_q.size() == 0) break;
      w = wr_q.pop_front();
      check($sformatf("sat_c%0d", k), {w.r, w.c, w.p}, {3'd0, CW'(k), 24'hFFFFFF});
    end

    // Row change coincident with an oe rise.
    for (int i = 0; i < NCH; i++) bits[i] = 1'($urandom_range(0, 1));
    shift_bits(bits, COLS);
    latch_now();
    repeat (3) oe_pulse();
    oe = 1'b1; row = 2;
    tick();
    snap_a = cnt;
    for (int i = 0; i < NCH; i++) cnt[i] = latched[i] ? 1 : 0;
    oe = 1'b0;
    tick();
    wait_writes(COLS, "simul");
    check_writes(snap_a, 1, COLS, "simul");
    repeat (2) oe_pulse();
    check("before_abort_no_error", 64'(framing_error), 64'(0));

    // Second row change 10 cycles into the row-2 flush.
    change_row(3);
    snap_b = snap_a;
    repeat (2) oe_pulse();
    repeat (6) tick();
    row = 4;
    tick();
    snap_c = cnt;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    check("abort_error", 64'(framing_error), 64'(1));
    wait_writes(10 + COLS, "abort");
    check_writes(snap_b, 2, 10, "abort_old");
    check_writes(snap_c, 3, COLS, "abort_new");

    // Reset while flushing at column 12.
    oe_pulse();
    change_row(5);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (wr_en === 1'b1 && wr_col == CW'(12)) found = 1'b1;
    end
    check("col12_reached", 64'(found), 64'(1));
    rst = 1'b1; row = '0;
    tick();
    check_idle("midflush_reset");
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    latched = '0;
    wr_q.delete();
    repeat (40) tick();
    check("no_writes_after_reset", 64'(wr_q.size()), 64'(0));

    // Short row: 31 bits then latch.
    for (int i = 0; i < NCH; i++) bits[i] = 1'($urandom_range(0, 1));
    shift_bits(bits, COLS - 1);
    latch_now();
    check("short_row_error", 64'(framing_error), 64'(1));
    shift_bits(bits, COLS);
    latch_now();
    repeat (5) tick();
    check("error_sticky", 64'(framing_error), 64'(1));

    // Latch while oe is high.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("error_cleared_by_reset", 64'(framing_error), 64'(0));
    shift_bits(bits, COLS);
    oe = 1'b1; tick();
    lat = 1'b1; tick();
    lat = 1'b0; oe = 1'b0; tick();
    check("lat_with_oe_error", 64'(framing_error), 64'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
